// File: rtl/fft_r2_combine_if.sv
// Stream interface for the radix-2 combine stage.
// Carries the lockstep E/T input pairs and the combined output samples with their frame markers.
interface fft_r2_combine_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned HALF_LEN = 16
);
    localparam int unsigned IW = $clog2(HALF_LEN) + 1;

    logic                    ED;
    logic                    START;
    logic                    SCALE;
    logic signed [WIDTH-1:0] ER;
    logic signed [WIDTH-1:0] EI;
    logic signed [WIDTH-1:0] TR;
    logic signed [WIDTH-1:0] TI;
    logic signed [WIDTH-1:0] DOReal;
    logic signed [WIDTH-1:0] DOImag;
    logic                    DOV;
    logic                    RDY;
    logic                    LAST;
    logic [IW-1:0]           IDX;
    logic                    OVF;

    modport master (
        output ED, START, SCALE, ER, EI, TR, TI,
        input  DOReal, DOImag, DOV, RDY, LAST, IDX, OVF
    );

    modport slave (
        input  ED, START, SCALE, ER, EI, TR, TI,
        output DOReal, DOImag, DOV, RDY, LAST, IDX, OVF
    );
endinterface

// File: rtl/fft_r2_combine.sv
// Final radix-2 DIT combine: streams E+T during input, then drains buffered E-T in natural order.
// Optional macro FFT_R2_SAT_EN: clamp overflowing results instead of wrapping.
module fft_r2_combine #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned HALF_LEN = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    fft_r2_combine_if.slave   bus
);
    localparam int unsigned AW = $clog2(HALF_LEN);
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              scale_q, scale_d;
    logic              ovf_q, ovf_d;
    logic              dov_q, dov_d;
    logic              rdy_q, rdy_d;
    logic              last_q, last_d;
    logic [AW:0]       idx_q, idx_d;
    logic [WIDTH-1:0]  re_q, re_d;
    logic [WIDTH-1:0]  im_q, im_d;

    logic [DW-1:0]     mem [HALF_LEN];
    logic              buf_we;
    logic [AW-1:0]     buf_wa;
    logic [DW-1:0]     buf_wd;
    logic [DW-1:0]     buf_rd;

    logic [WIDTH:0]    sum_re, sum_im, dif_re, dif_im;
    logic              scale_eff;
    logic              pair_ovf;

    // Scaled values cannot overflow; unscaled ones overflow when the two top bits disagree.
    function automatic logic ovf_of(input logic [WIDTH:0] v, input logic sc);
        return !sc && (v[WIDTH] != v[WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] v, input logic sc);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1:0];
        if (sc) begin
            r = v[WIDTH:1];
        end
`ifdef FFT_R2_SAT_EN
        else if (v[WIDTH] != v[WIDTH-1]) begin
            r = v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        return r;
    endfunction

    assign sum_re = {bus.ER[WIDTH-1], bus.ER} + {bus.TR[WIDTH-1], bus.TR};
    assign sum_im = {bus.EI[WIDTH-1], bus.EI} + {bus.TI[WIDTH-1], bus.TI};
    assign dif_re = {bus.ER[WIDTH-1], bus.ER} - {bus.TR[WIDTH-1], bus.TR};
    assign dif_im = {bus.EI[WIDTH-1], bus.EI} - {bus.TI[WIDTH-1], bus.TI};

    // A START edge uses the freshly presented SCALE for its own pair 0.
    assign scale_eff = bus.START ? bus.SCALE : scale_q;
    assign pair_ovf  = ovf_of(sum_re, scale_eff) | ovf_of(sum_im, scale_eff)
                     | ovf_of(dif_re, scale_eff) | ovf_of(dif_im, scale_eff);
    assign buf_rd    = mem[cnt_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scale_d = scale_q;
        ovf_d   = ovf_q;
        dov_d   = dov_q;
        rdy_d   = rdy_q;
        last_d  = last_q;
        idx_d   = idx_q;
        re_d    = re_q;
        im_d    = im_q;
        buf_we  = 1'b0;
        buf_wa  = bus.START ? '0 : cnt_q;
        buf_wd  = {fit(dif_im, scale_eff), fit(dif_re, scale_eff)};

        if (bus.ED) begin
            rdy_d  = 1'b0;
            last_d = 1'b0;
            if (bus.START) begin
                // New frame, aborting any frame in flight.
                state_d = FILL;
                cnt_d   = AW'(1);
                scale_d = bus.SCALE;
                ovf_d   = pair_ovf;
                dov_d   = 1'b1;
                rdy_d   = 1'b1;
                idx_d   = '0;
                re_d    = fit(sum_re, scale_eff);
                im_d    = fit(sum_im, scale_eff);
                buf_we  = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        dov_d = 1'b0;
                    end
                    FILL: begin
                        re_d   = fit(sum_re, scale_eff);
                        im_d   = fit(sum_im, scale_eff);
                        buf_we = 1'b1;
                        ovf_d  = ovf_q | pair_ovf;
                        idx_d  = {1'b0, cnt_q};
                        if (cnt_q == AW'(HALF_LEN - 1)) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                    DRAIN: begin
                        re_d  = buf_rd[WIDTH-1:0];
                        im_d  = buf_rd[DW-1:WIDTH];
                        idx_d = {1'b1, cnt_q};
                        if (cnt_q == AW'(HALF_LEN - 1)) begin
                            state_d = IDLE;
                            last_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scale_q <= 1'b0;
            ovf_q   <= 1'b0;
            dov_q   <= 1'b0;
            rdy_q   <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
            ovf_q   <= ovf_d;
            dov_q   <= dov_d;
            rdy_q   <= rdy_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    // Difference buffer; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            mem[buf_wa] <= buf_wd;
        end
    end

    assign bus.DOReal = re_q;
    assign bus.DOImag = im_q;
    assign bus.DOV    = dov_q;
    assign bus.RDY    = rdy_q;
    assign bus.LAST   = last_q;
    assign bus.IDX    = idx_q;
    assign bus.OVF    = ovf_q;
endmodule
